// File: rtl/divider1_pkg.sv
// Shared types and sizing for the restoring divider: FSM states, default width, counter width.
package divider1_pkg;

  localparam int DIV_N = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CNT_W = cnt_width(DIV_N);

endpackage

// File: rtl/divider1_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the divisor if it fits.
// Purely combinational; no handshake.
module divider1_step #(
  parameter int N = 8
) (
  input  logic [N-1:0] r_i,
  input  logic [N-1:0] q_i,
  input  logic [N-1:0] d_i,
  output logic [N-1:0] r_o,
  output logic [N-1:0] q_o
);

  // The partial remainder stays below D, so N bits hold it; only t needs the extra bit.
  logic [N:0] t;
  logic       ge;

  assign t   = {r_i, q_i[N-1]};
  assign ge  = (t >= {1'b0, d_i});
  assign r_o = ge ? N'(t - {1'b0, d_i}) : t[N-1:0];
  assign q_o = {q_i[N-2:0], ge};

endmodule

// File: rtl/divider1.sv
// Sequential unsigned 2N/N restoring divider, one quotient bit per clock (N+1 edges to ready).
// start is ignored while busy; ready and results hold until the next accepted start.
module divider1
  import divider1_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [2*N-1:0] A,
  input  logic [N-1:0]   B,
  output logic [N-1:0]   Quotient,
  output logic [N-1:0]   Remainder,
  output logic           overflow,
  output logic           dbz,
  output logic           ready
);

  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [N-1:0]    r_q, r_d;
  logic [N-1:0]    q_q, q_d;
  logic [N-1:0]    d_q;
  logic [N-1:0]    quot_q, rem_q;
  logic            ovf_q, dbz_q, rdy_q;
  logic            short_q;
  logic            hi_ge;

  assign hi_ge = (A[2*N-1:N] >= B);

  divider1_step #(.N(N)) u_step (
    .r_i (r_q),
    .q_i (q_q),
    .d_i (d_q),
    .r_o (r_d),
    .q_o (q_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
      dbz_q   <= 1'b0;
      rdy_q   <= 1'b0;
      short_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            r_q     <= A[2*N-1:N];
            q_q     <= A[N-1:0];
            d_q     <= B;
            cnt_q   <= '0;
            rdy_q   <= 1'b0;
            // B==0 always satisfies hi_ge, so divide-by-zero also flags overflow.
            dbz_q   <= (B == '0);
            ovf_q   <= hi_ge;
            short_q <= hi_ge;
            state_q <= CALC;
          end
        end
        CALC: begin
          if (short_q) begin
            quot_q  <= '1;
            rem_q   <= '1;
            rdy_q   <= 1'b1;
            state_q <= DONE;
          end else begin
            r_q <= r_d;
            q_q <= q_d;
            if (cnt_q == LAST) begin
              quot_q  <= q_d;
              rem_q   <= r_d;
              rdy_q   <= 1'b1;
              state_q <= DONE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Quotient  = quot_q;
  assign Remainder = rem_q;
  assign overflow  = ovf_q;
  assign dbz       = dbz_q;
  assign ready     = rdy_q;

endmodule

// File: tb/tb_divider1.sv
// Bench for divider1: vector table, busy/back-to-back/reset sequences, and random ops against a
// queue-based scoreboard of expected results.
module tb_divider1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] A;
  logic [7:0]  B;
  logic [7:0]  Quotient, Remainder;
  logic        overflow, dbz, ready;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  b;
    logic [7:0]  q;
    logic [7:0]  r;
    logic        ovf;
    logic        dbz;
    int          lat;
  } vec_t;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  b;
    logic [7:0]  q;
    logic [7:0]  r;
    logic        ovf;
    logic        dbz;
    int          lat;
    logic        inv;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[8];

  divider1 #(.N(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .A         (A),
    .B         (B),
    .Quotient  (Quotient),
    .Remainder (Remainder),
    .overflow  (overflow),
    .dbz       (dbz),
    .ready     (ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic launch(input logic [15:0] a, input logic [7:0] b, input logic [7:0] eq,
                        input logic [7:0] er, input logic eo, input logic ed, input int lat,
                        input logic inv);
    exp_t e;
    e.a = a; e.b = b; e.q = eq; e.r = er; e.ovf = eo; e.dbz = ed; e.lat = lat; e.inv = inv;
    A = a;
    B = b;
    start = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("ready_falls", 32'(ready), 32'd0);
  endtask

  task automatic wait_result(input string name, input int n0);
    int   n;
    exp_t e;
    n = n0;
    while (ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({name, "_ready"}, 32'(ready), 32'd1);
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_sb: scoreboard empty, got result %0h/%0h", name, Quotient, Remainder);
    end else begin
      e = sb.pop_front();
      check({name, "_lat"}, 32'(n), 32'(e.lat));
      check({name, "_q"}, 32'(Quotient), 32'(e.q));
      check({name, "_r"}, 32'(Remainder), 32'(e.r));
      check({name, "_ovf"}, 32'(overflow), 32'(e.ovf));
      check({name, "_dbz"}, 32'(dbz), 32'(e.dbz));
      if (e.inv) begin
        check({name, "_inv"}, 32'(Quotient) * 32'(e.b) + 32'(Remainder), 32'(e.a));
        check({name, "_rltb"}, 32'(Remainder < e.b), 32'd1);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rb, rhi, rlo;
    logic [15:0] ra;

    vecs[0] = '{16'h1234, 8'h56, 8'h36, 8'h10, 1'b0, 1'b0, 8};
    vecs[1] = '{16'hFEFF, 8'hFF, 8'hFF, 8'hFE, 1'b0, 1'b0, 8};
    vecs[2] = '{16'h5600, 8'h56, 8'hFF, 8'hFF, 1'b1, 1'b0, 1};
    vecs[3] = '{16'h0010, 8'h00, 8'hFF, 8'hFF, 1'b1, 1'b1, 1};
    vecs[4] = '{16'h0000, 8'h01, 8'h00, 8'h00, 1'b0, 1'b0, 8};
    vecs[5] = '{16'h01FF, 8'h02, 8'hFF, 8'h01, 1'b0, 1'b0, 8};
    vecs[6] = '{16'hFF00, 8'h10, 8'hFF, 8'hFF, 1'b1, 1'b0, 1};
    vecs[7] = '{16'h0064, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0, 8};

    rst_n = 1'b1;
    start = 1'b0;
    A = '0;
    B = '0;
    #3 rst_n = 1'b0;
    #1;
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_q", 32'(Quotient), 32'd0);
    check("rst_r", 32'(Remainder), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_dbz", 32'(dbz), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      launch(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].ovf, vecs[i].dbz, vecs[i].lat, 1'b0);
      wait_result($sformatf("vec%0d", i), 0);
      @(negedge clk);
    end

    // Start pulsed while busy must be ignored.
    launch(16'h1234, 8'h56, 8'h36, 8'h10, 1'b0, 1'b0, 8, 1'b0);
    repeat (2) @(negedge clk);
    A = 16'h0001;
    B = 8'h01;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_result("busy", 3);

    // Restart in the same cycle ready is high, then chain once more.
    check("b2b_ready_hi", 32'(ready), 32'd1);
    launch(16'h0064, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0, 8, 1'b0);
    wait_result("b2b0", 0);
    launch(16'h0010, 8'h00, 8'hFF, 8'hFF, 1'b1, 1'b1, 1, 1'b0);
    wait_result("b2b1", 0);
    launch(16'hFEFF, 8'hFF, 8'hFF, 8'hFE, 1'b0, 1'b0, 8, 1'b0);
    wait_result("b2b2", 0);

    // Reset in the middle of an operation.
    @(negedge clk);
    launch(16'h1234, 8'h56, 8'h36, 8'h10, 1'b0, 1'b0, 8, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 32'(ready), 32'd0);
    check("mid_rst_q", 32'(Quotient), 32'd0);
    check("mid_rst_r", 32'(Remainder), 32'd0);
    check("mid_rst_ovf", 32'(overflow), 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("mid_rst_hold", 32'(ready), 32'd0);
    end
    rst_n = 1'b1;
    sb.delete();
    launch(16'h0064, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0, 8, 1'b0);
    wait_result("post_rst", 0);

    for (int i = 0; i < 1000; i++) begin
      rb  = 8'($urandom_range(255, 1));
      rhi = 8'($urandom_range(32'(rb) - 1, 0));
      rlo = 8'($urandom);
      ra  = {rhi, rlo};
      launch(ra, rb, 8'(ra / 16'(rb)), 8'(ra % 16'(rb)), 1'b0, 1'b0, 8, 1'b1);
      wait_result($sformatf("rnd%0d", i), 0);
      if ($urandom_range(1, 0) == 1) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
